nibble_grid_serializer: RTL and testbench

NIBBLE_GRID_SERIALIZER -- requirements
Module: nibble_grid_serializer

---
 rtl/nibble_grid_serializer.sv | 139 +++++++++++++
 tb/tb_nibble_grid_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_grid_serializer.sv
// rtl/nibble_grid_serializer.sv - serializes a row-major nibble grid into indexed, tagged beats
// Define GRID_PARITY_EN to append an XOR parity beat after the data beats.
module nibble_grid_serializer #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4*NUM_ROWS*NUM_COLS-1:0] in_grid,
  input  logic [7:0]                     in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     out_nibble,
  output logic [3:0]                     out_index,
  output logic                           out_last,
  output logic [7:0]                     out_tag,
  output logic [7:0]                     pkt_count
);

  localparam int         N        = NUM_ROWS * NUM_COLS;
  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  // The beat counter is 4 bits and must also reach N for the parity beat.
  generate
    if (N < 1 || N > 14) begin : g_bad_grid_size
      $fatal(1, "nibble_grid_serializer: NUM_ROWS*NUM_COLS must be 1..14");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND
`ifdef GRID_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [4*N-1:0]   grid_q, grid_d;
  logic [7:0]       tag_q, tag_d;
  logic [3:0]       beat_q, beat_d;
  logic [7:0]       pkt_q, pkt_d;

  logic             is_last;
  logic             beat_hs;
  logic             last_hs;
  logic             accept;
  logic [3:0]       cur_nibble;
  logic [3:0]       data_nibble;

  assign out_valid = (state_q != S_IDLE);
  assign beat_hs   = out_valid && out_ready;

`ifdef GRID_PARITY_EN
  assign is_last = (state_q == S_PARITY);
`else
  assign is_last = (state_q == S_SEND) && (beat_q == LAST_IDX);
`endif

  assign last_hs  = beat_hs && is_last;
  // Ready on the final handshake lets the next grid follow with no bubble.
  assign in_ready = (state_q == S_IDLE) || last_hs;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    if (last_hs) begin
      pkt_d   = pkt_q + 8'd1;
      state_d = S_IDLE;
      beat_d  = '0;
    end else if (beat_hs) begin
`ifdef GRID_PARITY_EN
      if (beat_q == LAST_IDX) begin
        state_d = S_PARITY;
      end
`endif
      beat_d = beat_q + 4'd1;
    end
    if (accept) begin
      grid_d  = in_grid;
      tag_d   = in_tag;
      beat_d  = '0;
      state_d = S_SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grid_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
    end
  end

  always_comb begin
    cur_nibble = '0;
    for (int i = 0; i < N; i++) begin
      if (beat_q == 4'(i)) begin
        cur_nibble = grid_q[4*(N-1-i) +: 4];
      end
    end
  end

`ifdef GRID_PARITY_EN
  logic [3:0] parity;

  always_comb begin
    parity = '0;
    for (int i = 0; i < N; i++) begin
      parity = parity ^ grid_q[4*i +: 4];
    end
  end

  assign data_nibble = (state_q == S_PARITY) ? parity : cur_nibble;
`else
  assign data_nibble = cur_nibble;
`endif

  assign out_nibble = out_valid ? data_nibble : 4'h0;
  assign out_index  = out_valid ? beat_q : 4'h0;
  assign out_last   = is_last;
  assign out_tag    = out_valid ? tag_q : 8'h00;
  assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_nibble_grid_serializer.sv
// tb/tb_nibble_grid_serializer.sv - directed vector bench for nibble_grid_serializer
module tb_nibble_grid_serializer;

  localparam int N = 9;
`ifdef GRID_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_grid;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_nibble;
  logic [3:0]  out_index;
  logic        out_last;
  logic [7:0]  out_tag;
  logic [7:0]  pkt_count;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_pkts;

  always #5 clk = ~clk;

  nibble_grid_serializer #(.NUM_ROWS(3), .NUM_COLS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_grid    (in_grid),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_nibble (out_nibble),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_tag    (out_tag),
    .pkt_count  (pkt_count)
  );

  typedef struct {
    logic [35:0] grid;
    logic [7:0]  tag;
    logic [3:0]  par;
    logic [3:0]  rdy;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "/out_valid"},  out_valid,  1'b0);
    chk({pfx, "/out_nibble"}, out_nibble, 4'h0);
    chk({pfx, "/out_index"},  out_index,  4'h0);
    chk({pfx, "/out_last"},   out_last,   1'b0);
    chk({pfx, "/out_tag"},    out_tag,    8'h00);
  endtask

  function automatic logic [3:0] exp_nib(input vec_t v, input int b);
    if (b >= N) return v.par;
    return v.grid[4*(N-1-b) +: 4];
  endfunction

  task automatic run_packet(input vec_t v);
    int   beat;
    int   cyc;
    logic r;
    in_grid   = v.grid;
    in_tag    = v.tag;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    chk_idle("pre");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_grid  = ~v.grid;
    in_tag   = ~v.tag;
    beat = 0;
    cyc  = 0;
    while (beat < NB && cyc < 100) begin
      r = v.rdy[3 - (cyc % 4)];
      out_ready = r;
      #1;
      chk("beat_valid",    out_valid,  1'b1);
      chk("beat_nibble",   out_nibble, exp_nib(v, beat));
      chk("beat_index",    out_index,  beat);
      chk("beat_last",     out_last,   beat == NB - 1);
      chk("beat_tag",      out_tag,    v.tag);
      chk("beat_in_ready", in_ready,   r && (beat == NB - 1));
      @(posedge clk);
      @(negedge clk);
      if (r) beat++;
      cyc++;
    end
    chk("packet_done", beat, NB);
    exp_pkts  = exp_pkts + 8'd1;
    out_ready = 1'b0;
    #1;
    chk_idle("post");
    chk("pkt_count", pkt_count, exp_pkts);
  endtask

  initial begin
    int cnt;
    int cyc;

    vecs[0] = '{36'h123456789, 8'hA5, 4'h1, 4'b1111};
    vecs[1] = '{36'h123456789, 8'h5A, 4'h1, 4'b1001};
    vecs[2] = '{36'h000000000, 8'h00, 4'h0, 4'b1011};
    vecs[3] = '{36'hF0F0F0F0F, 8'hFF, 4'hF, 4'b0111};
    vecs[4] = '{36'h8421AB0C3, 8'h3C, 4'h1, 4'b1101};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_grid   = 36'h123456789;
    in_tag    = 8'h77;
    exp_pkts  = 8'd0;
    #1;
    chk_idle("reset");
    chk("reset/in_ready",  in_ready,  1'b1);
    chk("reset/pkt_count", pkt_count, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/no_accept", out_valid, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_packet(vecs[i]);
    end

    in_grid   = 36'h111111111;
    in_tag    = 8'h11;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_grid = 36'h222222222;
    in_tag  = 8'h22;
    for (int b = 0; b < 2*NB; b++) begin
      #1;
      chk("b2b_valid",    out_valid,  1'b1);
      chk("b2b_nibble",   out_nibble, (b < NB) ? 4'h1 : 4'h2);
      chk("b2b_index",    out_index,  b % NB);
      chk("b2b_last",     out_last,   (b % NB) == NB - 1);
      chk("b2b_tag",      out_tag,    (b < NB) ? 8'h11 : 8'h22);
      chk("b2b_in_ready", in_ready,   (b % NB) == NB - 1);
      @(posedge clk);
      @(negedge clk);
      if (b == NB - 1) in_valid = 1'b0;
    end
    #1;
    exp_pkts = exp_pkts + 8'd2;
    chk_idle("b2b_end");
    chk("b2b_pkt_count", pkt_count, exp_pkts);

    @(negedge clk);
    in_grid  = 36'h123456789;
    in_tag   = 8'hC3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid/index_before", out_index,  4'd5);
    chk("mid/nibble_before", out_nibble, 4'h6);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    chk("mid/pkt_count", pkt_count, 8'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_pkts = 8'd0;
    @(negedge clk);
    run_packet(vecs[0]);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    in_grid   = 36'h123456789;
    in_tag    = 8'h99;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cnt < 256 && cyc < 5000) begin
      #1;
      if (out_valid && out_last) begin
        cnt++;
        if (cnt == 256) begin
          chk("wrap/pre", pkt_count, 8'd255);
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    #1;
    chk("wrap/packets", cnt, 256);
    chk("wrap/pkt_count", pkt_count, 8'd0);
    chk("wrap/idle", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
